// File: rtl/open_file_struct_parser_pkg.sv
// Shared layout of the APF open-file struct (264 bytes, big-endian fields).
// Imported by the receive-side parser and the struct builder.
package open_file_struct_parser_pkg;

  localparam logic [8:0] PATH_BASE   = 9'h000;
  localparam logic [8:0] FLAGS_BASE  = 9'h100;
  localparam logic [8:0] SIZE_BASE   = 9'h104;
  localparam logic [8:0] STRUCT_LAST = 9'h107;
  localparam int         PATH_MAX    = 256;

  localparam int FLAG_CREATE = 0;
  localparam int FLAG_RESIZE = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Big-endian accumulate: the first byte received ends up in bits [31:24].
  function automatic logic [31:0] shift_in_be(input logic [31:0] acc,
                                              input logic [7:0]  b);
    return {acc[23:0], b};
  endfunction

endpackage

// File: rtl/open_file_struct_parser_if.sv
// Byte-stream handshake between the bridge and the open-file struct parser.
interface open_file_struct_parser_if;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );

endinterface

// File: rtl/open_file_struct_parser.sv
// Receives the 264-byte open-file struct, streams the path into a path RAM
// and captures path length, flags and file size.
module open_file_struct_parser
  import open_file_struct_parser_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 24
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  open_file_struct_parser_if.slave    bs,
  output logic                        path_wr,
  output logic [7:0]                  path_addr,
  output logic [7:0]                  path_data,
  output logic [8:0]                  path_length,
  output logic [31:0]                 flags,
  output logic [31:0]                 file_size,
  output logic                        struct_valid,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  state_t           state;
  logic [8:0]       cnt;
  logic [CNT_W-1:0] idle_cnt;
  logic             nul_found;
  logic             accept;

  logic             path_wr_p1;
  logic [7:0]       path_addr_p1;
  logic [7:0]       path_data_p1;

  assign bs.byte_ready = (state == ST_RECEIVE);
  // A start in the same cycle wins over the offered byte.
  assign accept        = bs.byte_valid && bs.byte_ready && !start;

  assign path_wr   = path_wr_p1;
  assign path_addr = path_addr_p1;
  assign path_data = path_data_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      idle_cnt     <= '0;
      nul_found    <= 1'b0;
      path_wr_p1   <= 1'b0;
      path_addr_p1 <= '0;
      path_data_p1 <= '0;
      path_length  <= '0;
      flags        <= '0;
      file_size    <= '0;
      struct_valid <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      path_wr_p1   <= 1'b0;
      struct_valid <= 1'b0;

      if (start) begin
        state       <= ST_RECEIVE;
        busy        <= 1'b1;
        cnt         <= '0;
        idle_cnt    <= '0;
        nul_found   <= 1'b0;
        path_length <= 9'(PATH_MAX);
        flags       <= '0;
        file_size   <= '0;
        timeout_err <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            busy <= 1'b0;
          end

          ST_RECEIVE: begin
            if (accept) begin
              idle_cnt <= '0;
              cnt      <= cnt + 9'd1;

              // ---- stage p1: registered path RAM write ----
              if (cnt < FLAGS_BASE) begin
                path_wr_p1   <= 1'b1;
                path_addr_p1 <= 8'(cnt - PATH_BASE);
                path_data_p1 <= bs.byte_data;
                if ((bs.byte_data == 8'h00) && !nul_found) begin
                  nul_found   <= 1'b1;
                  path_length <= cnt;
                end
              end else if (cnt < SIZE_BASE) begin
                flags <= shift_in_be(flags, bs.byte_data);
              end else begin
                file_size <= shift_in_be(file_size, bs.byte_data);
              end

              if (cnt == STRUCT_LAST) begin
                state        <= ST_DONE;
                busy         <= 1'b0;
                struct_valid <= 1'b1;
              end
            end else if (TO_EN) begin
              // Idle gap between accepted bytes; partial fields are kept.
              if (idle_cnt == TO_LAST) begin
                state       <= ST_IDLE;
                busy        <= 1'b0;
                timeout_err <= 1'b1;
              end else begin
                idle_cnt <= idle_cnt + CNT_W'(1);
              end
            end
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_open_file_struct_parser.sv
// Directed bench for open_file_struct_parser: table of whole structs plus
// hand-written sequences for timeout, restart, DONE hold and async reset.
module tb_open_file_struct_parser;
  import open_file_struct_parser_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        path_wr;
  logic [7:0]  path_addr;
  logic [7:0]  path_data;
  logic [8:0]  path_length;
  logic [31:0] flags;
  logic [31:0] file_size;
  logic        struct_valid;
  logic        busy;
  logic        timeout_err;

  open_file_struct_parser_if bus ();

  open_file_struct_parser #(
    .TIMEOUT_CYCLES (8),
    .CNT_W          (24)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .bs           (bus),
    .path_wr      (path_wr),
    .path_addr    (path_addr),
    .path_data    (path_data),
    .path_length  (path_length),
    .flags        (flags),
    .file_size    (file_size),
    .struct_valid (struct_valid),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] prefix;
    int          plen;
    logic [7:0]  fill;
    logic [31:0] flags;
    logic [31:0] size;
    bit          toggle;
    logic [8:0]  exp_len;
    logic [31:0] exp_flags;
    logic [31:0] exp_size;
  } vec_t;

  vec_t vecs [4];
  vec_t vr;

  int checks   = 0;
  int failures = 0;

  int         wr_total  = 0;
  int         sv_total  = 0;
  int         acc_total = 0;
  int         order_err = 0;
  logic [7:0] next_addr = 8'h00;
  logic [7:0] mem [256];

  // Observer: path writes, completion pulses and accepted bytes.
  always @(negedge clk) begin
    if (!reset_n) begin
      next_addr = 8'h00;
    end else begin
      if (path_wr) begin
        wr_total++;
        mem[path_addr] = path_data;
        if (path_addr !== next_addr) order_err++;
        next_addr = path_addr + 8'd1;
      end
      if (struct_valid) sv_total++;
      if (bus.byte_valid && bus.byte_ready && !start) acc_total++;
      if (start) next_addr = 8'h00;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] vbyte(input vec_t v, input int i);
    if (i < 256) return (i < v.plen) ? v.prefix[8*(v.plen-1-i) +: 8] : v.fill;
    else if (i < 260) return v.flags[8*(259-i) +: 8];
    else return v.size[8*(263-i) +: 8];
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bytes(input vec_t v, input int from, input int to);
    logic rdy;
    int   guard;
    for (int i = from; i <= to; i++) begin
      if (v.toggle) begin
        bus.byte_valid = 1'b0;
        tick();
      end
      bus.byte_data  = vbyte(v, i);
      bus.byte_valid = 1'b1;
      guard = 0;
      do begin
        rdy = bus.byte_ready;
        tick();
        guard++;
      end while (!rdy && guard < 4);
      if (!rdy) begin
        checks++;
        failures++;
        $display("FAIL accept_wait %s: byte %0d not accepted, ready=%0b expected 1", v.name, i, rdy);
        bus.byte_valid = 1'b0;
        return;
      end
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int sv0, wr0, acc0, oe0, bad;
    do_start();
    chk({v.name, " busy"}, 32'(busy), 32'd1);
    sv0 = sv_total; wr0 = wr_total; acc0 = acc_total; oe0 = order_err;
    send_bytes(v, 0, 263);
    chk({v.name, " struct_valid_pulse"}, 32'(struct_valid), 32'd1);
    chk({v.name, " busy_done"}, 32'(busy), 32'd0);
    tick();
    chk({v.name, " struct_valid_clear"}, 32'(struct_valid), 32'd0);
    chk({v.name, " path_length"}, 32'(path_length), 32'(v.exp_len));
    chk({v.name, " flags"}, flags, v.exp_flags);
    chk({v.name, " file_size"}, file_size, v.exp_size);
    chk({v.name, " path_writes"}, 32'(wr_total - wr0), 32'd256);
    chk({v.name, " accepts"}, 32'(acc_total - acc0), 32'd264);
    chk({v.name, " struct_valid_count"}, 32'(sv_total - sv0), 32'd1);
    chk({v.name, " addr_order_errors"}, 32'(order_err - oe0), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== vbyte(v, i)) bad++;
    chk({v.name, " path_ram_mismatches"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int sv0, wr0, bad;
    vec_t vt;

    vecs[0] = '{"abin", 64'h0, 5, 8'h00, 32'h00000003, 32'h00010000, 1'b0,
                9'd5, 32'h00000003, 32'h00010000};
    vecs[0].prefix = 64'(40'h612E62696E);  // "a.bin"
    vecs[1] = '{"nonul", 64'h0, 0, 8'h41, 32'h00000000, 32'hDEADBEEF, 1'b1,
                9'd256, 32'h00000000, 32'hDEADBEEF};
    vecs[2] = '{"midnul", 64'h0, 5, 8'h00, 32'h00000002, 32'h12345678, 1'b0,
                9'd2, 32'h00000002, 32'h12345678};
    vecs[2].prefix = 64'(40'h6162006364);  // "ab\0cd"
    vecs[3] = '{"nul0", 64'h0, 1, 8'h7F, 32'h80000001, 32'hFFFFFFFF, 1'b1,
                9'd0, 32'h80000001, 32'hFFFFFFFF};
    vr = '{"restart", 64'h78, 1, 8'h00, 32'h00000001, 32'h00000010, 1'b0,
           9'd1, 32'h00000001, 32'h00000010};

    reset_n        = 1'b0;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) tick();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst fields", {path_length, 23'd0} | flags | file_size, 32'd0);
    chk("rst pulses", {29'd0, path_wr, struct_valid, timeout_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    for (int k = 0; k < 4; k++) run_vec(vecs[k]);

    // DONE: offered bytes are ignored and outputs hold.
    sv0 = sv_total; wr0 = wr_total; bad = 0;
    bus.byte_data  = 8'hAB;
    bus.byte_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus.byte_ready !== 1'b0) bad++;
      tick();
    end
    bus.byte_valid = 1'b0;
    chk("done byte_ready_high_cycles", 32'(bad), 32'd0);
    chk("done path_writes", 32'(wr_total - wr0), 32'd0);
    chk("done struct_valid_count", 32'(sv_total - sv0), 32'd0);
    chk("done file_size_hold", file_size, 32'hFFFFFFFF);
    chk("done flags_hold", flags, 32'h80000001);
    chk("done path_length_hold", 32'(path_length), 32'd0);

    // Timeout after 100 bytes and 8 idle cycles.
    sv0 = sv_total;
    do_start();
    send_bytes(vecs[1], 0, 99);
    repeat (7) tick();
    chk("to err_before", 32'(timeout_err), 32'd0);
    chk("to busy_before", 32'(busy), 32'd1);
    tick();
    chk("to err_set", 32'(timeout_err), 32'd1);
    chk("to busy_clear", 32'(busy), 32'd0);
    chk("to byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("to path_length_partial", 32'(path_length), 32'd256);
    chk("to struct_valid_count", 32'(sv_total - sv0), 32'd0);
    do_start();
    chk("to err_cleared", 32'(timeout_err), 32'd0);
    chk("to busy_restart", 32'(busy), 32'd1);

    // start together with byte 0x105 restarts; only the second struct completes.
    sv0 = sv_total;
    vt = vecs[2];
    vt.flags = 32'hAAAA5555;
    send_bytes(vt, 0, 260);
    bus.byte_data  = vbyte(vt, 261);
    bus.byte_valid = 1'b1;
    start          = 1'b1;
    tick();
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    chk("rs105 flags_reinit", flags, 32'd0);
    chk("rs105 size_reinit", file_size, 32'd0);
    chk("rs105 busy", 32'(busy), 32'd1);
    send_bytes(vr, 0, 263);
    tick();
    chk("rs105 struct_valid_count", 32'(sv_total - sv0), 32'd1);
    chk("rs105 file_size", file_size, vr.exp_size);
    chk("rs105 flags", flags, vr.exp_flags);
    chk("rs105 path_length", 32'(path_length), 32'(vr.exp_len));

    // start together with the final byte: byte dropped, no completion.
    sv0 = sv_total;
    do_start();
    send_bytes(vecs[2], 0, 262);
    bus.byte_data  = vbyte(vecs[2], 263);
    bus.byte_valid = 1'b1;
    start          = 1'b1;
    tick();
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    chk("rs107 struct_valid", 32'(struct_valid), 32'd0);
    chk("rs107 busy", 32'(busy), 32'd1);
    chk("rs107 size_reinit", file_size, 32'd0);
    tick();
    chk("rs107 struct_valid_count", 32'(sv_total - sv0), 32'd0);
    send_bytes(vecs[3], 0, 263);
    tick();
    chk("rs107 second_complete", 32'(sv_total - sv0), 32'd1);
    chk("rs107 file_size", file_size, vecs[3].exp_size);

    // Asynchronous reset mid-path with a write in flight.
    do_start();
    send_bytes(vecs[1], 0, 49);
    chk("ar wr_in_flight", 32'(path_wr), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar path_wr", 32'(path_wr), 32'd0);
    chk("ar path_addr_data", {16'd0, path_addr, path_data}, 32'd0);
    chk("ar busy", 32'(busy), 32'd0);
    chk("ar byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("ar path_length", 32'(path_length), 32'd0);
    repeat (2) tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
